win_buff: RTL and testbench

//  Parametrised sliding-window line buffer for the HOG pixel front end. It accepts a raster pixel

---
 rtl/win_buff_pkg.sv | 15 +
 rtl/win_buff_line_mem.sv | 28 ++
 rtl/win_buff.sv | 125 ++++++++++++
 tb/tb_win_buff.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_buff_pkg.sv
// Shared helpers for the sliding-window line buffer and its downstream kernel consumers.
package win_buff_pkg;

   // Bit offset of kernel element [r][c][ch] inside the flattened window bus.
   function automatic int kidx(input int r, input int c, input int ch,
                               input int win_w, input int channels, input int pix_w);
      return ((r * win_w + c) * channels + ch) * pix_w;
   endfunction

   // Address width for a memory of the given depth, never narrower than one bit.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/win_buff_line_mem.sv
// One stored image line: asynchronous read, synchronous write. The top level reads and
// writes the same column in the same cycle, so the read returns the pre-write word.
module line_mem
   import win_buff_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 640,
   localparam int AW    = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write the incoming column word; contents are never reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/win_buff.sv
// Sliding-window line buffer: accepts a raster pixel stream and presents one
// WIN_H x WIN_W neighbourhood per accepted pixel once WIN_H-1 lines are stored.
// Row 0 of the window is the oldest line, column 0 the oldest column.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the output is a single register, so the input is ready only when that register
// is empty or is being drained in the same cycle.
module win_buff
   import win_buff_pkg::*;
#(
   parameter int PIX_W    = 8,
   parameter int CHANNELS = 1,
   parameter int MAX_LINE = 640,
   parameter int WIN_W    = 3,
   parameter int WIN_H    = 3,
   localparam int OUT_W   = WIN_W * WIN_H * CHANNELS * PIX_W,
   localparam int PX_W    = CHANNELS * PIX_W,
   localparam int LEN_W   = $clog2(MAX_LINE + 1),
   localparam int COL_W   = addr_w(MAX_LINE),
   localparam int ROW_W   = addr_w(WIN_H)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             flush,
   input  logic             p_valid,
   input  logic [PX_W-1:0]  pixel,
   output logic             p_ready,
   output logic             k_valid,
   output logic [OUT_W-1:0] kernel,
   output logic             k_border,
   input  logic             k_ready
);

   logic             w_acc;
   logic             w_lm_we;
   logic             w_last_col;
   logic             w_full;
   logic [LEN_W-1:0] w_col_ext;
   logic [PX_W-1:0]  w_vec [WIN_H];

   logic [PX_W-1:0]  r_win [WIN_H][WIN_W];
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_k_valid;
   logic             r_k_border;

   assign p_ready    = !rst && (!r_k_valid || k_ready);
   assign w_acc      = p_valid && p_ready;
   // A pixel arriving together with flush is dropped, so it must not touch the lines.
   assign w_lm_we    = w_acc && !flush;
   assign w_col_ext  = LEN_W'(r_col);
   assign w_last_col = (w_col_ext == cfg_len - LEN_W'(1));
   assign w_full     = (r_row == ROW_W'(WIN_H - 1));

   // Column vector: newest line comes straight from the input, older ones from the line stores.
   assign w_vec[WIN_H-1] = pixel;

   for (genvar gr = 0; gr < WIN_H - 1; gr++) begin : g_line
      line_mem #(
         .DATA_W (PX_W),
         .DEPTH  (MAX_LINE)
      ) u_line_mem (
         .clk     (clk),
         .i_we    (w_lm_we),
         .i_addr  (r_col),
         .i_wdata (w_vec[gr+1]),
         .o_rdata (w_vec[gr])
      );
   end

   // Shift the window one column left and load the new column vector on the right.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (w_lm_we) begin
         for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W - 1; c++) begin
               r_win[r][c] <= r_win[r][c+1];
            end
            r_win[r][WIN_W-1] <= w_vec[r];
         end
      end
   end

   // Raster position counters and the output valid/border register.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_col      <= '0;
         r_row      <= '0;
         r_k_valid  <= 1'b0;
         r_k_border <= 1'b0;
      end else if (w_acc) begin
         if (w_last_col) begin
            r_col <= '0;
            if (!w_full) begin
               r_row <= r_row + ROW_W'(1);
            end
         end else begin
            r_col <= r_col + COL_W'(1);
         end
         r_k_valid  <= w_full;
         r_k_border <= w_full && (r_col < COL_W'(WIN_W - 1));
      end else if (r_k_valid && k_ready) begin
         r_k_valid <= 1'b0;
      end
   end

   // Flatten the window registers onto the kernel bus.
   always_comb begin
      kernel = '0;
      for (int r = 0; r < WIN_H; r++) begin
         for (int c = 0; c < WIN_W; c++) begin
            kernel[kidx(r, c, 0, WIN_W, CHANNELS, PIX_W) +: PX_W] = r_win[r][c];
         end
      end
   end

   assign k_valid  = r_k_valid;
   assign k_border = r_k_border;

endmodule

// File: tb/tb_win_buff.sv
// Bench for win_buff: directed raster scenarios plus randomized frames, all windows
// checked against a frame-history reference model through an expected queue.
module tb_win_buff;

   localparam int PIX_W    = 8;
   localparam int CHANNELS = 3;
   localparam int MAX_LINE = 16;
   localparam int WIN_W    = 3;
   localparam int WIN_H    = 3;
   localparam int PX_W     = PIX_W * CHANNELS;
   localparam int OUT_W    = WIN_W * WIN_H * PX_W;
   localparam int LEN_W    = $clog2(MAX_LINE + 1);

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             p_valid;
   logic [PX_W-1:0]  pixel;
   logic [LEN_W-1:0] cfg_len;
   logic             k_ready = 1'b1;
   logic             p_ready;
   logic             k_valid;
   logic             k_border;
   logic [OUT_W-1:0] kernel;

   always #5 clk = ~clk;

   win_buff #(
      .PIX_W    (PIX_W),
      .CHANNELS (CHANNELS),
      .MAX_LINE (MAX_LINE),
      .WIN_W    (WIN_W),
      .WIN_H    (WIN_H)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_len  (cfg_len),
      .flush    (flush),
      .p_valid  (p_valid),
      .pixel    (pixel),
      .p_ready  (p_ready),
      .k_valid  (k_valid),
      .kernel   (kernel),
      .k_border (k_border),
      .k_ready  (k_ready)
   );

   // ---------------- scoreboard state ----------------
   logic [OUT_W-1:0] exp_q [$];
   logic [OUT_W-1:0] msk_q [$];
   logic             brd_q [$];
   logic [PX_W-1:0]  hist  [$];
   int               n_vec  = 0;
   int               n_fail = 0;
   logic             acc_s  = 1'b0;
   logic             stall_s = 1'b0;
   logic [OUT_W-1:0] prev_kernel;
   logic             prev_border;
   logic             kr_mode  = 1'b0;
   logic             kr_force = 1'b1;

   task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int koff(input int r, input int c, input int ch);
      return ((r * WIN_W + c) * CHANNELS + ch) * PIX_W;
   endfunction

   function automatic logic [PX_W-1:0] pix3(input int n);
      logic [PX_W-1:0] p;
      for (int ch = 0; ch < CHANNELS; ch++) p[ch*PIX_W +: PIX_W] = PIX_W'(n + ch);
      return p;
   endfunction

   // Reference: element [r][c] of the window after accepting frame pixel n is the pixel
   // accepted (WIN_W-1-c) + (WIN_H-1-r)*len positions earlier in the same frame.
   function automatic void model_push(input logic [PX_W-1:0] d, input int len);
      int n;
      int idx;
      int off;
      logic [OUT_W-1:0] e;
      logic [OUT_W-1:0] m;
      n = hist.size();
      hist.push_back(d);
      if (n / len >= WIN_H - 1) begin
         e = '0;
         m = '0;
         for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W; c++) begin
               idx = n - (WIN_W - 1 - c) - (WIN_H - 1 - r) * len;
               off = (r * WIN_W + c) * PX_W;
               if (idx >= 0) begin
                  e[off +: PX_W] = hist[idx];
                  m[off +: PX_W] = {PX_W{1'b1}};
               end
            end
         end
         exp_q.push_back(e);
         msk_q.push_back(m);
         brd_q.push_back((n % len) < WIN_W - 1);
      end
   endfunction

   // Monitor: ready rule, hold during backpressure, window compare on each handshake.
   always @(negedge clk) begin
      logic [OUT_W-1:0] e;
      logic [OUT_W-1:0] m;
      logic             b;
      chk("p_ready rule", OUT_W'(p_ready), OUT_W'(!rst && (!k_valid || k_ready)));
      if (stall_s) begin
         chk("hold k_valid", OUT_W'(k_valid), OUT_W'(1));
         chk("hold kernel", kernel, prev_kernel);
         chk("hold k_border", OUT_W'(k_border), OUT_W'(prev_border));
      end
      if (k_valid === 1'b1 && k_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious window", OUT_W'(k_valid), OUT_W'(0));
         end else begin
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            b = brd_q.pop_front();
            chk("kernel", kernel & m, e & m);
            chk("k_border", OUT_W'(k_border), OUT_W'(b));
         end
      end
      acc_s = p_valid && p_ready;
      if (rst || flush) begin
         hist.delete();
         exp_q.delete();
         msk_q.delete();
         brd_q.delete();
      end else if (acc_s) begin
         model_push(pixel, int'(cfg_len));
      end
      stall_s     = (k_valid === 1'b1) && !k_ready && !rst && !flush;
      prev_kernel = kernel;
      prev_border = k_border;
   end

   // Consumer: k_ready either forced by the directed sequence or randomized.
   always @(posedge clk) begin
      #2;
      k_ready = kr_mode ? ($urandom_range(0, 3) != 0) : kr_force;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [PX_W-1:0] d, input int gap);
      int t;
      p_valid = 1'b0;
      repeat (gap) step();
      p_valid = 1'b1;
      pixel   = d;
      t = 0;
      do begin
         @(posedge clk);
         t++;
      end while (!acc_s && t < 200);
      #1;
      p_valid = 1'b0;
      n_vec++;
      if (t >= 200) begin
         n_fail++;
         $display("FAIL accept timeout: pixel %0h not taken after %0d cycles", d, t);
      end
   endtask

   task automatic do_flush(input int len);
      flush   = 1'b1;
      p_valid = 1'b1;
      pixel   = PX_W'($urandom());
      cfg_len = LEN_W'(len);
      step();
      flush   = 1'b0;
      p_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int len;
      int npx;
      rst = 1'b1;
      flush = 1'b0;
      p_valid = 1'b0;
      pixel = '0;
      cfg_len = LEN_W'(4);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset k_valid", OUT_W'(k_valid), OUT_W'(0));
      chk("reset k_border", OUT_W'(k_border), OUT_W'(0));
      chk("reset kernel", kernel, '0);
      chk("reset p_ready", OUT_W'(p_ready), OUT_W'(1));
      step();

      // Two lines to fill the stores: no window yet.
      for (int n = 0; n < 8; n++) begin
         send(pix3(n), 0);
         chk("fill k_valid", OUT_W'(k_valid), OUT_W'(0));
      end

      // Third line: first windows.
      send(pix3(8), 0);
      chk("first k_valid", OUT_W'(k_valid), OUT_W'(1));
      chk("first k_border", OUT_W'(k_border), OUT_W'(1));
      send(pix3(9), 0);
      send(pix3(10), 0);
      chk("w10 k_border", OUT_W'(k_border), OUT_W'(0));
      for (int r = 0; r < WIN_H; r++) begin
         for (int c = 0; c < WIN_W; c++) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
               chk("w10 element", OUT_W'(kernel[koff(r, c, ch) +: PIX_W]), OUT_W'(r * 4 + c + ch));
            end
         end
      end
      send(pix3(11), 0);
      for (int r = 0; r < WIN_H; r++) begin
         for (int c = 0; c < WIN_W; c++) begin
            chk("w11 element", OUT_W'(kernel[koff(r, c, 0) +: PIX_W]), OUT_W'(r * 4 + c + 1));
         end
      end

      // Backpressure for three cycles while a window is pending.
      kr_force = 1'b0;
      fork
         send(pix3(12), 0);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("stall p_ready", OUT_W'(p_ready), OUT_W'(0));
               chk("stall k_valid", OUT_W'(k_valid), OUT_W'(1));
            end
            @(posedge clk);
            #1;
            kr_force = 1'b1;
         end
      join
      for (int n = 13; n < 16; n++) send(pix3(n), 0);

      // Pixel gaps mid-line.
      for (int n = 16; n < 24; n++) send(pix3(n), (n % 2 == 0) ? 5 : 0);

      // Stream to column 2, then flush with a new line length.
      send(pix3(24), 0);
      send(pix3(25), 0);
      do_flush(5);
      chk("flush k_valid", OUT_W'(k_valid), OUT_W'(0));
      for (int n = 0; n < 10; n++) begin
         send(pix3(100 + n), 0);
         chk("post-flush k_valid", OUT_W'(k_valid), OUT_W'(0));
      end
      send(pix3(110), 0);
      chk("11th k_valid", OUT_W'(k_valid), OUT_W'(1));

      // Reset while a window is held.
      kr_force = 1'b0;
      step();
      chk("held k_valid", OUT_W'(k_valid), OUT_W'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst k_valid", OUT_W'(k_valid), OUT_W'(0));
      chk("rst kernel", kernel, '0);
      kr_force = 1'b1;
      step();

      // Randomized frames with random line length, gaps and consumer stalls.
      kr_mode = 1'b1;
      for (int f = 0; f < 5; f++) begin
         len = $urandom_range(WIN_W, MAX_LINE);
         do_flush(len);
         npx = $urandom_range(2 * len, 5 * len);
         for (int i = 0; i < npx; i++) begin
            send(PX_W'($urandom()), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
         end
      end

      // Drain and confirm every expected window was delivered.
      kr_mode  = 1'b0;
      kr_force = 1'b1;
      repeat (6) step();
      chk("drain queue empty", OUT_W'(exp_q.size()), OUT_W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
